// File: rtl/par2ser_sched_if.sv
// par2ser_sched_if: requester, serializer-control and serial-beat bundle.
// master = scheduler side, slave = requesters/serializer/consumer side.
interface par2ser_sched_if #(
  parameter int NREQ  = 2,
  parameter int LANES = 7,
  parameter int DWO   = 32,
  parameter int NLW   = 3,
  parameter int SW    = 1,
  parameter int DWI   = LANES * DWO
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*DWI-1:0] req_data;
  logic [NREQ*NLW-1:0] req_nlane;
  logic [NREQ-1:0]     req_ready;
  logic                p2s_wen;
  logic                p2s_ren;
  logic [DWI-1:0]      p2s_din;
  logic                ser_valid;
  logic                ser_ready;
  logic                ser_last;
  logic [SW-1:0]       ser_src;
  logic                busy;

  modport master (
    input  req_valid, req_data, req_nlane, ser_ready,
    output req_ready, p2s_wen, p2s_ren, p2s_din,
    output ser_valid, ser_last, ser_src, busy
  );

  modport slave (
    output req_valid, req_data, req_nlane, ser_ready,
    input  req_ready, p2s_wen, p2s_ren, p2s_din,
    input  ser_valid, ser_last, ser_src, busy
  );
endinterface

// File: rtl/par2ser_sched.sv
// par2ser_sched: round-robin share of one par2ser between NREQ producers.
// Ports: clk, rst_n (async low), bus (par2ser_sched_if.master).
module par2ser_sched #(
  parameter int NREQ  = 2,
  parameter int LANES = 7,
  parameter int DWO   = 32,
  parameter int NLW   = 3,
  parameter int SW    = 1,
  parameter int DWI   = LANES * DWO
) (
  input  logic            clk,
  input  logic            rst_n,
  par2ser_sched_if.master bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]     state;
  logic [NLW-1:0] cnt;
  logic [SW-1:0]  src;
  logic [SW-1:0]  rr_last;

  logic           win_ok;
  logic [SW-1:0]  win;
  logic [DWI-1:0] win_data;
  logic [NLW-1:0] win_nl;
  logic [NLW-1:0] n_eff;
  logic           in_shift;
  logic           last_acc;
  logic           window;
  logic           grant;
  logic           load;

  always_comb begin
    int idx;
    idx    = 0;
    win_ok = 1'b0;
    win    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_last) + k) % NREQ;
      if (!win_ok && bus.req_valid[idx]) begin
        win_ok = 1'b1;
        win    = SW'(idx);
      end
    end
  end

  always_comb begin
    win_data = '0;
    win_nl   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == SW'(i)) begin
        win_data = bus.req_data[i*DWI +: DWI];
        win_nl   = bus.req_nlane[i*NLW +: NLW];
      end
    end
  end

  // compare one bit wider so the clamp stays meaningful at any NLW
  assign n_eff = ({1'b0, win_nl} > (NLW+1)'(LANES))
               ? NLW'(LANES) : win_nl;

  assign in_shift = (state == SHIFT);
  assign last_acc = in_shift && bus.ser_ready && (cnt == NLW'(1));
  // rst_n gate keeps req_ready low while reset is held
  assign window   = rst_n && (!in_shift || last_acc);
  assign grant    = window && win_ok;
  assign load     = grant && (n_eff != '0);

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = grant && (win == SW'(i));
    end
  end

  assign bus.p2s_wen   = load;
  assign bus.p2s_din   = load ? win_data : '0;
  assign bus.p2s_ren   = in_shift && bus.ser_ready;
  assign bus.ser_valid = in_shift;
  assign bus.busy      = in_shift;
  assign bus.ser_last  = in_shift && (cnt == NLW'(1));
  assign bus.ser_src   = in_shift ? src : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      src     <= '0;
      rr_last <= SW'(NREQ - 1);
    end else begin
      if (grant) begin
        rr_last <= win;
      end
      if (load) begin
        state <= SHIFT;
        cnt   <= n_eff;
        src   <= win;
      end else if (in_shift && bus.ser_ready) begin
        cnt <= cnt - NLW'(1);
        if (cnt == NLW'(1)) begin
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_par2ser_sched.sv
// tb_par2ser_sched: random + directed stimulus vs a transaction-level model.
// Model: per-requester pending words, round-robin pick, expected beat queue.
module tb_par2ser_sched;
  localparam int NREQ  = 2;
  localparam int LANES = 7;
  localparam int DWO   = 32;
  localparam int NLW   = 3;
  localparam int SW    = 1;
  localparam int DWI   = LANES * DWO;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  par2ser_sched_if #(
    .NREQ(NREQ), .LANES(LANES), .DWO(DWO),
    .NLW(NLW), .SW(SW)
  ) bus ();

  par2ser_sched #(
    .NREQ(NREQ), .LANES(LANES), .DWO(DWO),
    .NLW(NLW), .SW(SW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [DWO-1:0] d;
    logic           last;
    int             src;
  } beat_t;

  beat_t          exp_q[$];
  logic [DWI-1:0] sr;
  bit             pend[NREQ];
  logic [DWI-1:0] wd[NREQ];
  int             wn[NREQ];
  int             rr;
  int             checks = 0;
  int             errors = 0;
  int             gen_mode;
  int             rdy_mode;
  int             pat_i;
  int             beats;
  int             pat[5] = '{1, 0, 0, 1, 1};

  task automatic check(string tag, logic [DWI-1:0] got,
                       logic [DWI-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic new_word(int i, int nl, bit seq);
    for (int l = 0; l < LANES; l++) begin
      wd[i][l*DWO +: DWO] = seq ? 32'(32'h10 + l) : $urandom;
    end
    wn[i]   = nl;
    pend[i] = 1'b1;
  endtask

  task automatic check_quiet(string pfx);
    check({pfx, "_ser_valid"}, bus.ser_valid, 0);
    check({pfx, "_busy"}, bus.busy, 0);
    check({pfx, "_ser_last"}, bus.ser_last, 0);
    check({pfx, "_ser_src"}, bus.ser_src, 0);
    check({pfx, "_p2s_wen"}, bus.p2s_wen, 0);
    check({pfx, "_p2s_ren"}, bus.p2s_ren, 0);
    check({pfx, "_p2s_din"}, bus.p2s_din, 0);
    check({pfx, "_req_ready"}, bus.req_ready, 0);
  endtask

  task automatic cycle();
    bit  rdy;
    bit  win_open;
    int  w;
    int  n;
    beat_t b;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i]) begin
        if (gen_mode == 1)
          new_word(i, int'($urandom_range(7, 1)), 1'b0);
        else if (gen_mode == 3)
          new_word(i, 2, 1'b0);
        else if (gen_mode == 2 && $urandom_range(1, 0) == 1)
          new_word(i, int'($urandom_range(7, 0)), 1'b0);
      end else if (gen_mode == 2 && $urandom_range(15, 0) == 0) begin
        pend[i] = 1'b0;
      end
      bus.req_valid[i]             = pend[i];
      bus.req_data[i*DWI +: DWI]   = wd[i];
      bus.req_nlane[i*NLW +: NLW]  = NLW'(wn[i]);
    end
    if (rdy_mode == 0) begin
      rdy = 1'b1;
    end else if (rdy_mode == 1) begin
      rdy = 1'($urandom_range(1, 0));
    end else begin
      rdy = 1'(pat[pat_i % 5]);
      pat_i++;
    end
    bus.ser_ready = rdy;
    #1;
    check("ser_valid", bus.ser_valid, exp_q.size() != 0);
    check("busy", bus.busy, exp_q.size() != 0);
    check("p2s_ren", bus.p2s_ren, (exp_q.size() != 0) && rdy);
    if (exp_q.size() != 0) begin
      check("ser_last", bus.ser_last, exp_q[0].last);
      check("ser_src", bus.ser_src, exp_q[0].src);
    end
    win_open = (exp_q.size() == 0) || (exp_q.size() == 1 && rdy);
    w = -1;
    if (win_open) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (w < 0 && pend[(rr + k) % NREQ]) w = (rr + k) % NREQ;
      end
    end
    check("req_ready", bus.req_ready, (w >= 0) ? (1 << w) : 0);
    if (exp_q.size() != 0 && rdy) begin
      b = exp_q.pop_front();
      check("beat_data", sr[DWO-1:0], b.d);
      beats++;
    end
    if (w >= 0) begin
      n = (wn[w] > LANES) ? LANES : wn[w];
      check("p2s_wen", bus.p2s_wen, n != 0);
      check("p2s_din", bus.p2s_din, (n != 0) ? wd[w] : '0);
      for (int l = 0; l < n; l++) begin
        b.d    = wd[w][l*DWO +: DWO];
        b.last = (l == n - 1);
        b.src  = w;
        exp_q.push_back(b);
      end
      rr      = w;
      pend[w] = 1'b0;
    end else begin
      check("p2s_wen_idle", bus.p2s_wen, 0);
      check("p2s_din_idle", bus.p2s_din, 0);
    end
    // behavioural par2ser fed by the scheduler's strobes
    if (bus.p2s_wen) sr = bus.p2s_din;
    else if (bus.p2s_ren) sr = sr >> DWO;
  endtask

  task automatic run(int ncyc);
    for (int c = 0; c < ncyc; c++) cycle();
  endtask

  task automatic do_reset(string pfx);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_quiet(pfx);
    exp_q.delete();
    rr = NREQ - 1;
    sr = '0;
    @(negedge clk);
    bus.req_valid = '0;
    bus.ser_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      wd[i]   = '0;
      wn[i]   = 0;
    end
    rr = NREQ - 1;
    sr = '0;
    pat_i = 0;
    beats = 0;
    gen_mode = 0;
    rdy_mode = 0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_nlane = '0;
    bus.ser_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;

    new_word(0, 7, 1'b1);
    run(10);

    gen_mode = 3;
    run(12);
    gen_mode = 0;
    run(6);

    new_word(0, 3, 1'b0);
    rdy_mode = 2;
    run(12);
    rdy_mode = 0;

    new_word(0, 0, 1'b0);
    new_word(1, 1, 1'b0);
    run(6);
    new_word(0, 7, 1'b0);
    run(10);

    new_word(0, 7, 1'b1);
    beats = 0;
    guard = 0;
    while (beats < 2 && guard < 20) begin
      cycle();
      guard++;
    end
    check("midword_reach", beats >= 2, 1);
    new_word(0, 7, 1'b0);
    new_word(1, 4, 1'b0);
    do_reset("midrst");
    run(20);

    gen_mode = 2;
    rdy_mode = 1;
    run(2000);
    gen_mode = 0;
    run(40);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/par2ser_sched.md
# par2ser_sched

Round-robin scheduler that shares one `par2ser` serializer between `NREQ` parallel producers, such as PE-row result banks. It grants one producer at a time and drives `wen`, `ren` and `din` of the serializer. It then paces the serial beats to a valid/ready consumer, emitting `nlane` beats per granted word with last-beat and source tagging. The serial data path itself stays in `par2ser`: this block issues only controls and the load word, and the consumer takes `par2ser.dout` alongside `ser_valid`.

## Interface
- `NREQ`, 2: number of requesters.
- `LANES`, 7: lanes per parallel word.
- `DWO`, 32: lane width.
- `DWI`, `LANES*DWO`: parallel word width.
- `NLW`, 3: width of lane-count field; must hold `LANES`.
- `SW`, 1: source-id width; must be ≥ clog2(`NREQ`) and ≥ 1.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NREQ`  requester i has a word pending.
- `req_data`  in  `NREQ*DWI`  word of requester i at bits [i*DWI +: DWI].
- `req_nlane`  in  `NREQ*NLW`  valid lanes of requester i at [i*NLW +: NLW]; lane 0 is the LSB lane.
- `req_ready`  out  `NREQ`  one-hot grant; the word is consumed in the cycle `req_valid[i]` & `req_ready[i]` are both high.
- `p2s_wen`  out  1  load strobe to `par2ser`.
- `p2s_ren`  out  1  shift strobe to `par2ser`.
- `p2s_din`  out  `DWI`  load word to `par2ser`.
- `ser_valid`  out  1  `par2ser.dout` holds a valid lane.
- `ser_ready`  in  1  consumer accepts the current lane.
- `ser_last`  out  1  current lane is the final lane of its word.
- `ser_src`  out  `SW`  requester index that owns the current lane.
- `busy`  out  1  a word is being serialized (state SHIFT).

## Operation
- States: IDLE and SHIFT. Registers: `cnt` (`NLW` bits), `src` (`SW` bits), `rr_last` (`SW` bits).
- Arbitration window:
  - open in IDLE;
  - open in SHIFT in the cycle the last lane is accepted (`ser_valid` & `ser_ready` & `cnt`==1).
- Arbitration rule:
  - winner = first i with `req_valid[i]`=1, scanning from `rr_last`+1 upward modulo `NREQ`;
  - `req_ready` is combinational and one-hot for the winner, all zero when no request or outside the window;
  - `rr_last` ← winner on every grant.
- Lane-count normalization: effective n = min(`req_nlane`, `LANES`).
- Grant with n ≥ 1:
  - `p2s_wen`=1 and `p2s_din`=winner's word in the same cycle;
  - `cnt`←n, `src`←winner, next state SHIFT.
- Grant with n = 0:
  - the word is consumed with `p2s_wen`=0 and no beats are emitted;
  - next state is IDLE; no second grant is issued in that cycle.
- SHIFT:
  - `ser_valid`=1, `ser_src`=`src`, `ser_last`=(`cnt`==1);
  - on `ser_ready`: `p2s_ren`=1 and `cnt`←`cnt`−1;
  - on the last beat with no new grant, next state is IDLE;
  - on the last beat with a new grant, `p2s_wen` and `p2s_ren` are both 1. `par2ser` gives `wen` priority, so the new word loads and the next state stays SHIFT.
- Outside SHIFT: `p2s_ren`=0.
- Outside a grant: `p2s_wen`=0 and `p2s_din`=0.
- `ser_valid` drops only after the last beat is accepted; while `ser_ready`=0, no outputs and no state change.

## Timing
- Reset (async, `rst_n`=0), all cleared immediately:
  - state=IDLE, `cnt`=0, `src`=0;
  - `rr_last`=`NREQ`−1, so requester 0 wins first;
  - all outputs 0.
- Reset mid-word: the in-flight word is dropped and no further beats are emitted. The `par2ser` reset clears the shift register.
- Grant cycle T, load takes effect at T+1: first `ser_valid` at T+1.
- Throughput: with `ser_ready` held 1 and requests always pending, a word of n lanes occupies exactly n cycles with zero bubbles between words.
- The consumer samples `par2ser.dout` at `ser_valid` & `ser_ready`.
- `req_valid` may drop without a grant. Requesters must hold `req_data` and `req_nlane` stable while valid.

## Test plan
- Reset then single word: requester 0 has `nlane`=7 and lanes 0x10..0x16; `ser_ready`=1. Expect the grant at T, beats 0x10..0x16 at T+1..T+7 with `ser_last` only on 0x16, `ser_src`=0, then `busy`=0.
- Round-robin fairness: both requesters always valid, `nlane`=2. Expect grant order 0,1,0,1, with each new grant coinciding with the prior last beat, and no idle cycle over 8 beats.
- Backpressure: `nlane`=3 with `ser_ready` toggling 1,0,0,1,1. Expect 3 beats delivered in order, `p2s_ren` asserted only in accepted cycles, and `cnt`/outputs frozen during stalls.
- Boundary counts: `nlane`=0 gives a grant, no `p2s_wen`, no beats, and a return to IDLE. `nlane`=1 gives one beat with `ser_last`=1. `nlane`=7 gives 7 beats (max, equal to `LANES`; `nlane` > `LANES` is unreachable at default widths).
- Reset mid-word: assert `rst_n`=0 after beat 2 of 7. Expect all outputs 0 immediately. After release, requester 0 (not the prior winner's successor) wins first and a fresh word serializes from lane 0.
